// File: rtl/cordic_chan_sched.sv
// cordic_chan_sched
// Shares one CORDIC pipeline across NCH NCO channels. Each sample tick starts
// a frame that issues one phase per channel, then drains the pipeline while a
// tag pipe tracks which returning result belongs to which channel.

module cordic_chan_sched #(
    parameter int NCH = 4,
    parameter int PW  = 19,
    parameter int OW  = 15,
    parameter int LAT = 16,
    localparam int CW = $clog2(NCH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_tick,
    input  logic          i_cfg_we,
    input  logic [CW-1:0] i_cfg_ch,
    input  logic [PW-1:0] i_cfg_ftw,
    input  logic          i_phase_clr,
    input  logic          i_ovr_clr,
    output logic          o_cordic_ce,
    output logic [PW-1:0] o_phase,
    output logic [CW-1:0] o_issue_ch,
    input  logic [OW-1:0] i_res_x,
    input  logic [OW-1:0] i_res_y,
    output logic          o_res_valid,
    output logic [CW-1:0] o_res_ch,
    output logic [OW-1:0] o_res_x,
    output logic [OW-1:0] o_res_y,
    output logic          o_busy,
    output logic          o_overrun
);

    localparam int DW = $clog2(LAT + 1);
    localparam logic [CW-1:0] KLAST = CW'(NCH - 1);
    localparam logic [DW-1:0] DLAST = DW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          w_start;
    logic          w_ce;
    logic          w_busy;
    logic [PW-1:0] w_phase;
    logic [CW-1:0] w_issueCh;

    logic [CW-1:0] r_k;
    logic [DW-1:0] r_drain;

    logic [PW-1:0] r_acc    [NCH];
    logic [PW-1:0] r_ftwAct [NCH];
    logic [PW-1:0] r_ftwSh  [NCH];
    logic          r_clrPend;
    logic          r_overrun;

    logic          r_tagV  [LAT];
    logic [CW-1:0] r_tagCh [LAT];

    logic          r_resValid;
    logic [CW-1:0] r_resCh;
    logic [OW-1:0] r_resX;
    logic [OW-1:0] r_resY;

    // Frame sequencer state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the issue-side outputs (ce, phase, channel)
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_ce        = 1'b0;
        w_busy      = 1'b0;
        w_phase     = '0;
        w_issueCh   = '0;
        case (r_state)
            S_IDLE: begin
                if (i_tick) begin
                    w_nextState = S_ISSUE;
                    w_start     = 1'b1;
                end
            end
            S_ISSUE: begin
                w_ce      = 1'b1;
                w_busy    = 1'b1;
                w_phase   = r_acc[r_k];
                w_issueCh = r_k;
                if (r_k == KLAST) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_ce   = 1'b1;
                w_busy = 1'b1;
                if (r_drain == DLAST) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Channel counter for ISSUE and cycle counter for DRAIN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_k     <= '0;
            r_drain <= '0;
        end else begin
            if (w_start) begin
                r_k <= '0;
            end else if (r_state == S_ISSUE) begin
                r_k <= r_k + CW'(1);
            end
            if (r_state == S_DRAIN && r_drain != DLAST) begin
                r_drain <= r_drain + DW'(1);
            end else begin
                r_drain <= '0;
            end
        end
    end

    // Phase accumulators and active FTWs; both only change at frame start or on issue
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c]    <= '0;
                r_ftwAct[c] <= '0;
            end
        end else if (w_start) begin
            for (int c = 0; c < NCH; c++) begin
                r_ftwAct[c] <= r_ftwSh[c];
                if (r_clrPend || i_phase_clr) begin
                    r_acc[c] <= '0;
                end
            end
        end else if (r_state == S_ISSUE) begin
            r_acc[r_k] <= r_acc[r_k] + r_ftwAct[r_k];
        end
    end

    // Shadow FTWs accept writes at any time; they reach the datapath at the next frame start
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_ftwSh[c] <= '0;
            end
        end else if (i_cfg_we) begin
            r_ftwSh[i_cfg_ch] <= i_cfg_ftw;
        end
    end

    // Remember a phase-clear request until it is consumed by a frame start
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clrPend <= 1'b0;
        end else if (w_start) begin
            r_clrPend <= 1'b0;
        end else if (i_phase_clr) begin
            r_clrPend <= 1'b1;
        end
    end

    // Sticky overrun: a tick while busy sets it and beats a simultaneous clear
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (i_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    // Tag pipe shadows the CORDIC pipeline and only moves when the pipeline moves
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < LAT; s++) begin
                r_tagV[s]  <= 1'b0;
                r_tagCh[s] <= '0;
            end
        end else if (w_ce) begin
            r_tagV[0]  <= (r_state == S_ISSUE);
            r_tagCh[0] <= r_k;
            for (int s = 1; s < LAT; s++) begin
                r_tagV[s]  <= r_tagV[s-1];
                r_tagCh[s] <= r_tagCh[s-1];
            end
        end
    end

    // Capture the CORDIC result when a valid tag reaches the head of the pipe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_resValid <= 1'b0;
            r_resCh    <= '0;
            r_resX     <= '0;
            r_resY     <= '0;
        end else begin
            r_resValid <= 1'b0;
            if (w_ce && r_tagV[LAT-1]) begin
                r_resValid <= 1'b1;
                r_resCh    <= r_tagCh[LAT-1];
                r_resX     <= i_res_x;
                r_resY     <= i_res_y;
            end
        end
    end

    assign o_cordic_ce = w_ce;
    assign o_busy      = w_busy;
    assign o_phase     = w_phase;
    assign o_issue_ch  = w_issueCh;
    assign o_overrun   = r_overrun;
    assign o_res_valid = r_resValid;
    assign o_res_ch    = r_resCh;
    assign o_res_x     = r_resX;
    assign o_res_y     = r_resY;

endmodule
